// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for one port of the shared RAM arbiter.
// The master modport is the requester and the slave modport is the arbiter.
interface mem_port_arbiter_if;
  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (core / debug loader) arbiter in front of a single-port word RAM.
// It provides bounded lock bursts, error responses for bad addresses, and registered read returns.
module mem_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   c_port,
  mem_port_arbiter_if.slave   d_port,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [31:0]         m_wdata,
  input  logic [31:0]         m_rdata
);

  localparam int            BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    C_OWN = 2'd1,
    D_OWN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;        // 0 = core granted last, 1 = debug
  logic [BW-1:0] burst_q, burst_d;
  logic [BW-1:0] burst_inc;

  logic          c_rvalid_q, c_rvalid_d;
  logic          c_err_q, c_err_d;
  logic [31:0]   c_rdata_q, c_rdata_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          d_err_q, d_err_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic          c_win, d_win, owner_keeps;
  logic          c_gnt, d_gnt;
  logic          c_bad, d_bad;

  // Misaligned or beyond the RAM: still granted, but answered with an error.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
  endfunction

  assign c_bad = addr_bad(c_port.addr);
  assign d_bad = addr_bad(d_port.addr);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    c_win       = 1'b0;
    d_win       = 1'b0;
    owner_keeps = (((state_q == C_OWN) && c_port.lock) ||
                   ((state_q == D_OWN) && d_port.lock)) && (burst_q < BURST_LAST);
    if (c_port.req && !d_port.req) begin
      c_win = 1'b1;
    end else if (d_port.req && !c_port.req) begin
      d_win = 1'b1;
    end else if (c_port.req && d_port.req) begin
      if (owner_keeps) begin
        c_win = (state_q == C_OWN);
        d_win = (state_q == D_OWN);
      end else begin
        c_win = last_q;
        d_win = !last_q;
      end
    end
  end

  // Grants are held off for as long as reset is asserted, so nothing reaches the RAM.
  assign c_gnt = c_win & reset;
  assign d_gnt = d_win & reset;

  always_comb begin
    m_addr  = c_port.addr[ADDR_W+1:2];
    m_wdata = c_port.wdata;
    m_we    = c_gnt & c_port.we & ~c_bad;
    if (d_gnt) begin
      m_addr  = d_port.addr[ADDR_W+1:2];
      m_wdata = d_port.wdata;
      m_we    = d_port.we & ~d_bad;
    end
  end

  assign burst_inc = (burst_q == BURST_LAST) ? burst_q : burst_q + 1'b1;

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    burst_d = '0;
    if (c_gnt) begin
      state_d = C_OWN;
      last_d  = 1'b0;
      if ((state_q == C_OWN) && c_port.lock) burst_d = burst_inc;
    end else if (d_gnt) begin
      state_d = D_OWN;
      last_d  = 1'b1;
      if ((state_q == D_OWN) && d_port.lock) burst_d = burst_inc;
    end

    // Reads and bad accesses answer next cycle; rdata holds between responses.
    c_rvalid_d = c_gnt & (~c_port.we | c_bad);
    c_err_d    = c_gnt & c_bad;
    c_rdata_d  = c_rdata_q;
    if (c_rvalid_d) c_rdata_d = c_bad ? 32'h0 : m_rdata;

    d_rvalid_d = d_gnt & (~d_port.we | d_bad);
    d_err_d    = d_gnt & d_bad;
    d_rdata_d  = d_rdata_q;
    if (d_rvalid_d) d_rdata_d = d_bad ? 32'h0 : m_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      burst_q    <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= 32'h0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      c_rvalid_q <= c_rvalid_d;
      c_err_q    <= c_err_d;
      c_rdata_q  <= c_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign c_port.gnt    = c_gnt;
  assign c_port.rvalid = c_rvalid_q;
  assign c_port.err    = c_err_q;
  assign c_port.rdata  = c_rdata_q;
  assign d_port.gnt    = d_gnt;
  assign d_port.rvalid = d_rvalid_q;
  assign d_port.err    = d_err_q;
  assign d_port.rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and random traffic.
// A history-based arbitration/memory reference model checks every cycle.
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 6;
  localparam int MAX_BURST = 4;
  localparam int WORDS     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  mem_port_arbiter_if c_if ();
  mem_port_arbiter_if d_if ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .reset   (reset),
    .c_port  (c_if),
    .d_port  (d_if),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment RAM, loaded on the first clock edge, combinational read.
  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
  endfunction

  logic [31:0] ram [WORDS];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (m_we) begin
      ram[m_addr] <= m_wdata;
    end
  end
  assign m_rdata = ram[m_addr];

  // ---------------- reference model ----------------
  typedef struct { int who; bit lock; } grant_rec_t;
  grant_rec_t  hist[$];
  int          last_who;
  bit          ex_rv  [2];
  bit          ex_err [2];
  logic [31:0] ex_rd  [2];
  logic [31:0] mem_m  [WORDS];

  // Count of back-to-back locked re-grants of the current owner, saturated.
  function automatic int locked_run();
    int n = 0;
    int i = hist.size() - 1;
    while (i > 0 && hist[i].who >= 0 && hist[i].lock && hist[i-1].who == hist[i].who) begin
      n++;
      i--;
    end
    return (n > MAX_BURST - 1) ? MAX_BURST - 1 : n;
  endfunction

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * WORDS));
  endfunction

  initial begin : model
    logic        rq [2];
    logic        wr [2];
    logic        lk [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        gt [2];
    logic        rv [2];
    logic        er [2];
    logic [31:0] rd [2];
    int          g, owner, idx;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we, glock;
    for (int i = 0; i < WORDS; i++) mem_m[i] = init_word(i);
    last_who = 1;
    for (int p = 0; p < 2; p++) begin ex_rv[p] = 0; ex_err[p] = 0; ex_rd[p] = 0; end
    forever begin
      @(negedge clk);
      rq[0] = c_if.req;  wr[0] = c_if.we;  lk[0] = c_if.lock;  ad[0] = c_if.addr;  wd[0] = c_if.wdata;
      rq[1] = d_if.req;  wr[1] = d_if.we;  lk[1] = d_if.lock;  ad[1] = d_if.addr;  wd[1] = d_if.wdata;
      gt[0] = c_if.gnt;  rv[0] = c_if.rvalid;  er[0] = c_if.err;  rd[0] = c_if.rdata;
      gt[1] = d_if.gnt;  rv[1] = d_if.rvalid;  er[1] = d_if.err;  rd[1] = d_if.rdata;
      if (!reset) begin
        for (int p = 0; p < 2; p++) begin
          check(p ? "rst_d_gnt" : "rst_c_gnt", gt[p], 0);
          check(p ? "rst_d_rvalid" : "rst_c_rvalid", rv[p], 0);
          check(p ? "rst_d_rdata" : "rst_c_rdata", rd[p], 0);
        end
        check("rst_m_we", m_we, 0);
        hist.delete();
        last_who = 1;
        for (int p = 0; p < 2; p++) begin ex_rv[p] = 0; ex_err[p] = 0; ex_rd[p] = 0; end
      end else begin
        for (int p = 0; p < 2; p++) begin
          check(p ? "mdl_d_rvalid" : "mdl_c_rvalid", rv[p], ex_rv[p]);
          if (ex_rv[p]) check(p ? "mdl_d_err" : "mdl_c_err", er[p], ex_err[p]);
          check(p ? "mdl_d_rdata" : "mdl_c_rdata", rd[p], ex_rd[p]);
        end
        owner = (hist.size() > 0) ? hist[$].who : -1;
        if (rq[0] && !rq[1])      g = 0;
        else if (rq[1] && !rq[0]) g = 1;
        else if (rq[0] && rq[1]) begin
          if (owner >= 0 && lk[owner] && locked_run() < MAX_BURST - 1) g = owner;
          else g = 1 - last_who;
        end else g = -1;
        check("mdl_c_gnt", gt[0], (g == 0));
        check("mdl_d_gnt", gt[1], (g == 1));
        exp_addr  = ad[0];
        exp_wdata = wd[0];
        exp_we    = 1'b0;
        glock     = 1'b0;
        if (g >= 0) begin
          exp_addr  = ad[g];
          exp_wdata = wd[g];
          exp_we    = wr[g] && !is_bad(ad[g]);
          glock     = lk[g];
        end
        check("mdl_m_addr", 32'(m_addr), (exp_addr / 4) % WORDS);
        check("mdl_m_wdata", m_wdata, exp_wdata);
        check("mdl_m_we", m_we, exp_we);
        for (int p = 0; p < 2; p++) begin ex_rv[p] = 0; ex_err[p] = 0; end
        if (g >= 0) begin
          idx = int'((ad[g] / 4) % WORDS);
          if (is_bad(ad[g])) begin
            ex_rv[g] = 1; ex_err[g] = 1; ex_rd[g] = 0;
          end else if (!wr[g]) begin
            ex_rv[g] = 1; ex_rd[g] = mem_m[idx];
          end else begin
            mem_m[idx] = wd[g];
          end
          last_who = g;
        end
        hist.push_back('{who: g, lock: glock});
        if (hist.size() > 2 * MAX_BURST) void'(hist.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic c_req, c_we, c_lock; logic [31:0] c_addr, c_wdata;
    logic d_req, d_we, d_lock; logic [31:0] d_addr, d_wdata;
    logic e_cg, e_dg, e_mwe; logic [ADDR_W-1:0] e_maddr;
    logic e_crv, e_cerr; logic [31:0] e_crd;
    logic e_drv, e_derr; logic [31:0] e_drd;
  } vec_t;
  vec_t vt [13];

  task automatic drive_c(input logic req, we, lock, input logic [31:0] addr, wdata);
    c_if.req = req; c_if.we = we; c_if.lock = lock; c_if.addr = addr; c_if.wdata = wdata;
  endtask

  task automatic drive_d(input logic req, we, lock, input logic [31:0] addr, wdata);
    d_if.req = req; d_if.we = we; d_if.lock = lock; d_if.addr = addr; d_if.wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_c(0, 0, 0, 0, 0);
    drive_d(0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return {24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    int  dn, wait_c, max_wait;
    bit  c_pend, d_pend;
    logic cg, dg;

    //          c: req we lk addr      wdata        d: req we lk addr       wdata          cg dg we ma   crv ce crd            drv de drd
    vt[0]  = '{1, 0, 0, 32'h8,   32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 0, 0, 6'd2, 0, 0, 32'h0,        0, 0, 32'h0};
    vt[1]  = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 6'd0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0};
    vt[2]  = '{0, 0, 0, 32'h0,   32'h0,        1, 1, 0, 32'h4,   32'h12345678, 0, 1, 1, 6'd1, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0};
    vt[3]  = '{1, 0, 0, 32'h4,   32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 0, 0, 6'd1, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0};
    vt[4]  = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 6'd0, 1, 0, 32'h12345678, 0, 0, 32'h0};
    vt[5]  = '{0, 0, 0, 32'h0,   32'h0,        1, 1, 0, 32'h102, 32'hFFFFFFFF, 0, 1, 0, 6'd0, 0, 0, 32'h12345678, 0, 0, 32'h0};
    vt[6]  = '{0, 0, 0, 32'h0,   32'h0,        1, 1, 0, 32'h100, 32'hFFFFFFFF, 0, 1, 0, 6'd0, 0, 0, 32'h12345678, 1, 1, 32'h0};
    vt[7]  = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 6'd0, 0, 0, 32'h12345678, 1, 1, 32'h0};
    vt[8]  = '{1, 0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 0, 0, 6'd0, 0, 0, 32'h12345678, 0, 0, 32'h0};
    vt[9]  = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 6'd0, 1, 0, 32'hA0000000, 0, 0, 32'h0};
    vt[10] = '{1, 0, 0, 32'h8,   32'h0,        1, 0, 0, 32'hC,   32'h0,        0, 1, 0, 6'd3, 0, 0, 32'hA0000000, 0, 0, 32'h0};
    vt[11] = '{1, 0, 0, 32'h8,   32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 0, 0, 6'd2, 0, 0, 32'hA0000000, 1, 0, 32'hA0000003};
    vt[12] = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 6'd0, 1, 0, 32'hDEADBEEF, 0, 0, 32'hA0000003};

    reset = 1'b1;
    drive_c(0, 0, 0, 0, 0);
    drive_d(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < $size(vt); i++) begin
      drive_c(vt[i].c_req, vt[i].c_we, vt[i].c_lock, vt[i].c_addr, vt[i].c_wdata);
      drive_d(vt[i].d_req, vt[i].d_we, vt[i].d_lock, vt[i].d_addr, vt[i].d_wdata);
      @(negedge clk);
      check($sformatf("tbl%0d_c_gnt", i), c_if.gnt, vt[i].e_cg);
      check($sformatf("tbl%0d_d_gnt", i), d_if.gnt, vt[i].e_dg);
      check($sformatf("tbl%0d_m_we", i), m_we, vt[i].e_mwe);
      check($sformatf("tbl%0d_m_addr", i), 32'(m_addr), 32'(vt[i].e_maddr));
      check($sformatf("tbl%0d_c_rvalid", i), c_if.rvalid, vt[i].e_crv);
      if (vt[i].e_crv) check($sformatf("tbl%0d_c_err", i), c_if.err, vt[i].e_cerr);
      check($sformatf("tbl%0d_c_rdata", i), c_if.rdata, vt[i].e_crd);
      check($sformatf("tbl%0d_d_rvalid", i), d_if.rvalid, vt[i].e_drv);
      if (vt[i].e_drv) check($sformatf("tbl%0d_d_err", i), d_if.err, vt[i].e_derr);
      check($sformatf("tbl%0d_d_rdata", i), d_if.rdata, vt[i].e_drd);
      tick();
    end

    // Unlocked contention from reset alternates core/debug.
    do_reset();
    drive_c(1, 0, 0, 32'h8, 0);
    drive_d(1, 0, 0, 32'hC, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("alt%0d_c_gnt", k), c_if.gnt, (k % 2 == 0));
      check($sformatf("alt%0d_d_gnt", k), d_if.gnt, (k % 2 == 1));
      check($sformatf("alt%0d_one_gnt", k), c_if.gnt & d_if.gnt, 0);
      tick();
    end

    // Locked debug burst against a waiting core: D,D,D,D,C repeating.
    do_reset();
    dn = 0; wait_c = 0; max_wait = 0;
    drive_d(1, 1, 1, 32'h40, 32'h0);
    for (int k = 0; k < 12; k++) begin
      if (k >= 1) drive_c(1, 0, 0, 32'h8, 0);
      @(negedge clk);
      check($sformatf("burst%0d_gnt", k), {30'h0, c_if.gnt, d_if.gnt}, (k % 5 == 4) ? 2 : 1);
      if (c_if.req && !c_if.gnt) wait_c++;
      else wait_c = 0;
      if (wait_c > max_wait) max_wait = wait_c;
      dg = d_if.gnt;
      tick();
      if (dg) dn++;
      if (dn < 10) drive_d(1, 1, 1, 32'h40 + 32'(4 * dn), 32'(dn));
      else drive_d(0, 0, 0, 0, 0);
    end
    check("burst_d_grants", dn, 10);
    check("burst_c_max_wait", max_wait, 4);
    drive_c(0, 0, 0, 0, 0);
    tick();

    // Reset during a pending read response.
    drive_c(1, 0, 0, 32'h8, 0);
    @(negedge clk);
    check("rst_pre_c_gnt", c_if.gnt, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_d(1, 1, 0, 32'h4, 32'hBAD0BAD0);
    @(negedge clk);
    check("rst_drop_c_rvalid", c_if.rvalid, 0);
    check("rst_hold_c_gnt", c_if.gnt, 0);
    check("rst_hold_d_gnt", d_if.gnt, 0);
    check("rst_hold_m_we", m_we, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_tie_c_gnt", c_if.gnt, 1);
    check("rst_tie_d_gnt", d_if.gnt, 0);
    tick();
    drive_d(0, 0, 0, 0, 0);
    drive_c(1, 0, 0, 32'h4, 0);
    @(negedge clk);
    tick();
    drive_c(0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_ram_kept_rvalid", c_if.rvalid, 1);
    check("rst_ram_kept_rdata", c_if.rdata, 32'h12345678);
    tick();

    // Random traffic obeying the hold-until-grant rule.
    c_pend = 0;
    d_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1;
        drive_c(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end else if (!c_pend) begin
        c_if.req = 1'b0;
      end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1;
        drive_d(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end else if (!d_pend) begin
        d_if.req = 1'b0;
      end
      @(negedge clk);
      cg = c_if.gnt;
      dg = d_if.gnt;
      tick();
      if (cg) c_pend = 0;
      if (dg) d_pend = 0;
    end

    drive_c(0, 0, 0, 0, 0);
    drive_d(0, 0, 0, 0, 0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
